uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: data width, requester count and the tx arbiter state encoding.
package uart_tx_arbiter_pkg;
    localparam int UART_DATA_W = 8;
    localparam int NUM_REQ     = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } arb_state_t;

    // The round-robin pointer only breaks ties; a lone requester always wins.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] req, input logic ptr);
        logic winner;
        if (req[0] && req[1]) begin
            winner = ptr;
        end else begin
            winner = req[1];
        end
        return winner;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester message arbiter in front of a uart_tx: one owner at a time, whole messages,
// round-robin between owners, with a timeout on the uart_tx busy handshake.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [UART_DATA_W-1:0] data0,
    input  logic                   last0,
    output logic                   ack0,
    input  logic                   req1,
    input  logic [UART_DATA_W-1:0] data1,
    input  logic                   last1,
    output logic                   ack1,
    output logic [NUM_REQ-1:0]     grant,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic                   err
);
    localparam int              CNT_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

    arb_state_t             state_reg, state_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic                   ptr_reg, ptr_next;
    logic [UART_DATA_W-1:0] tx_data_reg, tx_data_next;
    logic                   last_reg, last_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   err_reg, err_next;

    logic [NUM_REQ-1:0]     req_vec;
    logic [NUM_REQ-1:0]     ack_vec;
    logic                   winner;
    logic                   owner;
    logic                   owner_req;
    logic                   owner_last;
    logic [UART_DATA_W-1:0] owner_data;
    logic [CNT_W-1:0]       cnt_inc;

    assign req_vec    = {req1, req0};
    assign winner     = pick_winner(req_vec, ptr_reg);
    assign owner      = grant_reg[1];
    assign owner_req  = owner ? req1 : req0;
    assign owner_last = owner ? last1 : last0;
    assign owner_data = owner ? data1 : data0;
    assign cnt_inc    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= 1'b0;
            tx_data_reg <= '0;
            last_reg    <= 1'b0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            ptr_reg     <= ptr_next;
            tx_data_reg <= tx_data_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        ptr_next     = ptr_reg;
        tx_data_next = tx_data_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((|req_vec) && !tx_busy) begin
                    grant_next = {winner, ~winner};
                    state_next = LOAD;
                end
            end
            LOAD: begin
                tx_data_next = owner_data;
                last_next    = owner_last;
                state_next   = SEND;
            end
            SEND: begin
                cnt_next   = '0;
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        err_next   = 1'b1;
                        grant_next = '0;
                        ptr_next   = ~owner;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    // A dropped req without a last byte is an abort: end the message here.
                    if (last_reg || !owner_req) begin
                        grant_next = '0;
                        ptr_next   = ~owner;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_vec = '0;
        tx_send = 1'b0;
        if (state_reg == LOAD) begin
            ack_vec = grant_reg;
        end
        if (state_reg == SEND) begin
            tx_send = 1'b1;
        end
    end

    assign ack0    = ack_vec[0];
    assign ack1    = ack_vec[1];
    assign grant   = grant_reg;
    assign tx_data = tx_data_reg;
    assign err     = err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester messages, a stubbed uart_tx busy
// flag, and a message-level round-robin model predicting the order of transmitted bytes.
module tb_uart_tx_arbiter;
    localparam int T = 12;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } byte_t;

    typedef struct packed {
        logic       who;
        logic [7:0] d;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       req0, req1, last0, last1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, tx_send, tx_busy, err;
    logic [1:0] grant;
    logic [7:0] tx_data;

    uart_tx_arbiter #(.BUSY_TIMEOUT(T)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .data0   (data0),
        .last0   (last0),
        .ack0    (ack0),
        .req1    (req1),
        .data1   (data1),
        .last1   (last1),
        .ack1    (ack1),
        .grant   (grant),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    byte_t q0[$];
    byte_t q1[$];
    exp_t  exp_q[$];
    int    exp_err = 0;
    int    cyc = 0;
    int    last_send_cyc = 0;
    int    ack_cnt0 = 0, ack_cnt1 = 0;
    int    exp_ack0 = 0, exp_ack1 = 0;
    bit    stub_dead = 1'b0;
    bit    model_ptr = 1'b0;

    // Round description: messages per requester, their lengths, abort flag and bytes.
    int         nmsg[2];
    int         mlen[2][2];
    bit         mabort[2][2];
    logic [7:0] mbytes[2][2][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    task automatic drive_reqs();
        req0 = 1'b0; data0 = 8'h00; last0 = 1'b0;
        req1 = 1'b0; data1 = 8'h00; last1 = 1'b0;
        if (q0.size() > 0) begin
            req0 = 1'b1; data0 = q0[0].d; last0 = q0[0].last;
        end
        if (q1.size() > 0) begin
            req1 = 1'b1; data1 = q1[0].d; last1 = q1[0].last;
        end
    endtask

    // Requesters: a byte seen acked during a cycle is consumed at the following edge.
    initial begin
        bit seen0, seen1;
        seen0 = 1'b0;
        seen1 = 1'b0;
        drive_reqs();
        forever begin
            @(negedge clk);
            if (!reset) begin
                seen0 = 1'b0;
                seen1 = 1'b0;
            end else begin
                if (seen0 && q0.size() > 0) void'(q0.pop_front());
                if (seen1 && q1.size() > 0) void'(q1.pop_front());
                seen0 = ack0;
                seen1 = ack1;
            end
            drive_reqs();
        end
    end

    // uart_tx stand-in: busy rises 1..3 cycles after a send and stays high 2..6 cycles.
    initial begin
        int dly, hold;
        dly = 0;
        hold = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tx_busy = 1'b0; dly = 0; hold = 0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) tx_busy = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    hold = $urandom_range(6, 2);
                end
            end else if (tx_send && !stub_dead) begin
                dly = $urandom_range(3, 1);
            end
        end
    end

    // Monitor: pops the scoreboard on every send, checks lock on acks and timing of err.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (tx_send) begin
                    last_send_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_send: tx_data %0h sent, no byte expected", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.d));
                        check("send_owner", 32'(grant), e.who ? 32'd2 : 32'd1);
                    end
                end
                if (ack0) begin
                    ack_cnt0++;
                    check("lock_ack0", 32'(grant), 32'd1);
                end
                if (ack1) begin
                    ack_cnt1++;
                    check("lock_ack1", 32'(grant), 32'd2);
                end
                if (err) begin
                    if (exp_err > 0) begin
                        exp_err--;
                        check("err_delay", cyc - last_send_cyc, T + 1);
                        check("err_grant", 32'(grant), 32'd0);
                    end else begin
                        n_checks++;
                        $display("FAIL unexpected_err: err=1, expected 0");
                    end
                end
            end
        end
    end

    // Loads the round into the requester queues and predicts the byte order message by message.
    task automatic post_round();
        int  nx[2];
        bit  p0, p1;
        int  w;
        exp_t x;
        nx[0] = 0;
        nx[1] = 0;
        ack_cnt0 = 0; ack_cnt1 = 0; exp_ack0 = 0; exp_ack1 = 0;
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < nmsg[r]; m++) begin
                for (int b = 0; b < mlen[r][m]; b++) begin
                    byte_t e;
                    e.d    = mbytes[r][m][b];
                    e.last = (b == mlen[r][m] - 1) && !mabort[r][m];
                    if (r == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
        while (nx[0] < nmsg[0] || nx[1] < nmsg[1]) begin
            p0 = nx[0] < nmsg[0];
            p1 = nx[1] < nmsg[1];
            if (p0 && p1) w = int'(model_ptr);
            else w = p1 ? 1 : 0;
            for (int b = 0; b < mlen[w][nx[w]]; b++) begin
                x.who = w[0];
                x.d   = mbytes[w][nx[w]][b];
                exp_q.push_back(x);
            end
            if (w == 0) exp_ack0 += mlen[w][nx[w]];
            else exp_ack1 += mlen[w][nx[w]];
            nx[w]++;
            model_ptr = (w == 0);
        end
        drive_reqs();
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && grant == 2'b00 && !tx_busy)
               && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_complete"}, 32'(k < 3000), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_acks0"}, ack_cnt0, exp_ack0);
        check({name, "_acks1"}, ack_cnt1, exp_ack1);
        check({name, "_err_pending"}, exp_err, 0);
        check({name, "_grant_idle"}, 32'(grant), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        exp_err = 0;
        model_ptr = 1'b0;
        drive_reqs();
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_acks", 32'({ack1, ack0}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
    endtask

    task automatic clear_round();
        nmsg[0] = 0;
        nmsg[1] = 0;
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < 2; m++) begin
                mlen[r][m] = 1;
                mabort[r][m] = 1'b0;
                for (int b = 0; b < 4; b++) mbytes[r][m][b] = 8'($urandom);
            end
        end
    endtask

    initial begin
        int k;
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // "Hi" from requester 0, with request-to-send latency
        do_reset();
        clear_round();
        nmsg[0] = 1; mlen[0][0] = 2; mbytes[0][0][0] = 8'h48; mbytes[0][0][1] = 8'h69;
        @(negedge clk);
        post_round();
        @(negedge clk);
        check("lat_ack0", 32'(ack0), 32'd1);
        @(negedge clk);
        check("lat_send", 32'(tx_send), 32'd1);
        wait_done("hi");

        // Simultaneous requests after reset: requester 0 first, then 3 bytes from requester 1
        do_reset();
        clear_round();
        nmsg[0] = 1; mlen[0][0] = 2;
        nmsg[1] = 1; mlen[1][0] = 3;
        @(negedge clk);
        post_round();
        wait_done("simul");

        // Requester 0 re-requests immediately: the second arbitration must go to requester 1
        do_reset();
        clear_round();
        nmsg[0] = 2; mlen[0][0] = 1; mlen[0][1] = 2;
        nmsg[1] = 1; mlen[1][0] = 2;
        @(negedge clk);
        post_round();
        wait_done("alternate");

        // Busy never rises: err after the timeout, then grant released
        stub_dead = 1'b1;
        clear_round();
        nmsg[0] = 1; mlen[0][0] = 1;
        exp_err = 1;
        @(negedge clk);
        post_round();
        wait_done("timeout");
        stub_dead = 1'b0;

        // Owner aborts after 3 bytes with no last flag; requester 1 is served next
        do_reset();
        clear_round();
        nmsg[0] = 1; mlen[0][0] = 3; mabort[0][0] = 1'b1;
        nmsg[1] = 1; mlen[1][0] = 2;
        @(negedge clk);
        post_round();
        wait_done("abort");

        // Reset in WAIT_LO of requester 0's second byte; afterwards only requester 1 asks
        do_reset();
        clear_round();
        nmsg[0] = 1; mlen[0][0] = 4;
        @(negedge clk);
        post_round();
        k = 0;
        while (!(tx_busy && ack_cnt0 >= 2) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midmsg_reached", 32'(k < 500), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_tx_send", 32'(tx_send), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_acks", 32'({ack1, ack0}), 32'd0);
        check("async_tx_data", 32'(tx_data), 32'd0);
        q0.delete(); exp_q.delete();
        model_ptr = 1'b0;
        drive_reqs();
        @(negedge clk);
        clear_round();
        nmsg[1] = 1; mlen[1][0] = 3;
        post_round();
        repeat (2) @(negedge clk);
        check("held_in_reset", 32'(grant), 32'd0);
        reset = 1'b1;
        wait_done("after_reset");

        // Randomised rounds against the message-level model
        for (int r = 0; r < 16; r++) begin
            clear_round();
            nmsg[0] = $urandom_range(2, 0);
            nmsg[1] = $urandom_range(2, 0);
            if (nmsg[0] == 0 && nmsg[1] == 0) nmsg[0] = 1;
            for (int q = 0; q < 2; q++) begin
                for (int m = 0; m < nmsg[q]; m++) begin
                    mlen[q][m] = $urandom_range(4, 1);
                    mabort[q][m] = (m == nmsg[q] - 1) && ($urandom_range(3, 0) == 0);
                end
            end
            @(negedge clk);
            post_round();
            wait_done("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
